fifo512_ctrl: RTL and testbench

Pointer and flag controller that turns a `mem512b` 512×8 synchronous RAM into a byte FIFO for the DMA data path. It sits directly in front of the RAM. It drives the RAM's read address, write address, write data and write enable, and it delivers the RAM's 1-clock-latency read data to the consumer with a matching valid strobe. It also provides full, empty, almost-full and occupancy status, so the DMA engine can throttle bursts.

---
 rtl/fifo512_ctrl_if.sv | 31 +++
 rtl/fifo512_ctrl.sv | 76 +++++++
 tb/tb_fifo512_ctrl.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/fifo512_ctrl_if.sv
// Consumer/producer and RAM-side signals of the 512x8 FIFO controller.
// The controller uses the slave view; the data-path client plus RAM use the master view.
interface fifo512_ctrl_if;
    logic       clear;
    logic       wr_req;
    logic [7:0] wr_data;
    logic       rd_req;
    logic       rd_valid;
    logic [7:0] rd_data;
    logic       full;
    logic       empty;
    logic       afull;
    logic [9:0] count;
    logic [8:0] mem_rdaddr;
    logic [8:0] mem_wraddr;
    logic [7:0] mem_datain;
    logic       mem_we;
    logic [7:0] mem_dataout;

    modport master (
        output clear, wr_req, wr_data, rd_req, mem_dataout,
        input  rd_valid, rd_data, full, empty, afull, count,
        input  mem_rdaddr, mem_wraddr, mem_datain, mem_we
    );

    modport slave (
        input  clear, wr_req, wr_data, rd_req, mem_dataout,
        output rd_valid, rd_data, full, empty, afull, count,
        output mem_rdaddr, mem_wraddr, mem_datain, mem_we
    );
endinterface

// File: rtl/fifo512_ctrl.sv
// Pointer/flag controller turning a 512x8 synchronous RAM into a byte FIFO.
// Push/pop acceptance uses only registered flags, so no request reaches a flag combinationally.
module fifo512_ctrl #(
    parameter int unsigned AFULL_LVL = 448
) (
    input logic           clk,
    input logic           rst_n,
    fifo512_ctrl_if.slave bus
);

    localparam logic [9:0] AFULL_CNT = 10'(AFULL_LVL);
    localparam logic [9:0] FULL_CNT  = 10'd512;

    logic [8:0] wr_ptr;
    logic [8:0] rd_ptr;
    logic [9:0] count_q;
    logic [9:0] count_next;
    logic       full_q;
    logic       empty_q;
    logic       afull_q;
    logic       rd_valid_q;
    logic       push;
    logic       pop;

    // rst_n gating keeps the RAM write strobe low while reset is held.
    assign push = rst_n & bus.wr_req & ~full_q  & ~bus.clear;
    assign pop  = rst_n & bus.rd_req & ~empty_q & ~bus.clear;

    assign bus.mem_we     = push;
    assign bus.mem_wraddr = wr_ptr;
    assign bus.mem_rdaddr = rd_ptr;
    assign bus.mem_datain = bus.wr_data;
    assign bus.rd_data    = bus.mem_dataout;
    assign bus.rd_valid   = rd_valid_q;
    assign bus.full       = full_q;
    assign bus.empty      = empty_q;
    assign bus.afull      = afull_q;
    assign bus.count      = count_q;

    always_comb begin
        count_next = count_q;
        if (bus.clear) begin
            count_next = '0;
        end else if (push && !pop) begin
            count_next = count_q + 10'd1;
        end else if (pop && !push) begin
            count_next = count_q - 10'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count_q    <= '0;
            empty_q    <= 1'b1;
            full_q     <= 1'b0;
            afull_q    <= 1'b0;
            rd_valid_q <= 1'b0;
        end else begin
            if (bus.clear) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + 9'd1;
                if (pop)  rd_ptr <= rd_ptr + 9'd1;
            end
            count_q    <= count_next;
            empty_q    <= (count_next == 10'd0);
            full_q     <= (count_next == FULL_CNT);
            afull_q    <= (count_next >= AFULL_CNT);
            rd_valid_q <= pop;
        end
    end

endmodule

// File: tb/tb_fifo512_ctrl.sv
// Bench for fifo512_ctrl: RAM model, queue-based reference, per-cycle compare and directed cases.
module tb_fifo512_ctrl;

    localparam int AFULL = 448;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    fifo512_ctrl_if bus();

    fifo512_ctrl #(.AFULL_LVL(AFULL)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [7:0] ram [512];
    always @(posedge clk) begin
        if (bus.mem_we) ram[bus.mem_wraddr] <= bus.mem_datain;
        bus.mem_dataout <= ram[bus.mem_rdaddr];
    end

    // Reference: a byte queue plus wrapped pointer indices.
    byte unsigned q[$];
    int           wp = 0;
    int           rp = 0;
    bit           ev = 1'b0;
    logic [7:0]   ed = 8'h00;

    function automatic bit m_push();
        return rst_n && bus.wr_req && !bus.clear && (q.size() < 512);
    endfunction

    function automatic bit m_pop();
        return rst_n && bus.rd_req && !bus.clear && (q.size() > 0);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n || bus.clear) begin
            q.delete();
            wp = 0;
            rp = 0;
            ev = 1'b0;
        end else begin
            bit p;
            bit o;
            p  = m_push();
            o  = m_pop();
            ev = o;
            if (o) begin
                ed = q.pop_front();
                rp = (rp + 1) % 512;
            end
            if (p) begin
                q.push_back(bus.wr_data);
                wp = (wp + 1) % 512;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("count", 32'(bus.count), 32'(q.size()));
        chk("empty", 32'(bus.empty), 32'(q.size() == 0));
        chk("full", 32'(bus.full), 32'(q.size() == 512));
        chk("afull", 32'(bus.afull), 32'(q.size() >= AFULL));
        chk("rd_valid", 32'(bus.rd_valid), 32'(ev));
        chk("wraddr", 32'(bus.mem_wraddr), 32'(wp));
        chk("rdaddr", 32'(bus.mem_rdaddr), 32'(rp));
        if (ev) chk("rd_data", 32'(bus.rd_data), 32'(ed));
        #3;
        chk("mem_we", 32'(bus.mem_we), 32'(m_push()));
        chk("collision", 32'(bus.mem_we && m_pop() && (bus.mem_wraddr == bus.mem_rdaddr)), 32'd0);
    end

    task automatic step(input bit w, input logic [7:0] d, input bit r, input bit c = 1'b0);
        @(negedge clk);
        #1;
        bus.wr_req  = w;
        bus.wr_data = d;
        bus.rd_req  = r;
        bus.clear   = c;
        @(posedge clk);
        #2;
    endtask

    task automatic fill_drain();
        for (int i = 0; i < 512; i++) begin
            step(1'b1, 8'(i), 1'b0);
            if (i == 446) chk("afull_447", 32'(bus.afull), 32'd0);
            if (i == 447) chk("afull_448", 32'(bus.afull), 32'd1);
            if (i == 510) chk("full_511", 32'(bus.full), 32'd0);
        end
        chk("full_512", 32'(bus.full), 32'd1);
        chk("count_512", 32'(bus.count), 32'd512);
        step(1'b1, 8'h77, 1'b0);
        chk("count_over", 32'(bus.count), 32'd512);
        for (int i = 0; i < 512; i++) begin
            step(1'b0, 8'h00, 1'b1);
            chk("drain_data", 32'(bus.rd_data), 32'(i & 255));
        end
        step(1'b0, 8'h00, 1'b0);
        chk("drain_empty", 32'(bus.empty), 32'd1);
    endtask

    initial begin
        bus.clear   = 1'b0;
        bus.wr_req  = 1'b0;
        bus.wr_data = 8'h00;
        bus.rd_req  = 1'b0;
        #2 rst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            bus.wr_req  = 1'($urandom_range(0, 1));
            bus.rd_req  = 1'($urandom_range(0, 1));
            bus.clear   = 1'($urandom_range(0, 1));
            bus.wr_data = 8'($urandom);
        end
        bus.wr_req = 1'b1;
        bus.clear  = 1'b0;
        #2;
        chk("rst_count", 32'(bus.count), 32'd0);
        chk("rst_empty", 32'(bus.empty), 32'd1);
        chk("rst_full", 32'(bus.full), 32'd0);
        chk("rst_rd_valid", 32'(bus.rd_valid), 32'd0);
        chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
        @(negedge clk);
        #1;
        bus.wr_req = 1'b0;
        bus.rd_req = 1'b0;
        rst_n      = 1'b1;

        step(1'b1, 8'hA5, 1'b0);
        chk("first_count", 32'(bus.count), 32'd1);
        step(1'b0, 8'h00, 1'b1);
        chk("first_valid", 32'(bus.rd_valid), 32'd1);
        chk("first_data", 32'(bus.rd_data), 32'hA5);
        step(1'b0, 8'h00, 1'b0);
        chk("first_valid_drop", 32'(bus.rd_valid), 32'd0);

        fill_drain();
        for (int i = 0; i < 299; i++) step(1'b1, 8'h00, 1'b0);
        for (int i = 0; i < 299; i++) step(1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b0);
        chk("offset_ptr", 32'(bus.mem_wraddr), 32'd300);
        fill_drain();

        step(1'b1, 8'h11, 1'b1);
        chk("both_empty_count", 32'(bus.count), 32'd1);
        chk("both_empty_valid", 32'(bus.rd_valid), 32'd0);
        for (int i = 0; i < 4; i++) step(1'b1, 8'(8'h20 + i), 1'b0);
        step(1'b1, 8'h30, 1'b1);
        chk("both_5_count", 32'(bus.count), 32'd5);
        chk("both_5_data", 32'(bus.rd_data), 32'h11);
        for (int i = 0; i < 5; i++) step(1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 512; i++) step(1'b1, 8'(i), 1'b0);
        step(1'b1, 8'hEE, 1'b1);
        chk("both_full_count", 32'(bus.count), 32'd511);
        for (int i = 0; i < 511; i++) step(1'b0, 8'h00, 1'b1);

        for (int i = 0; i < 200; i++) step(1'b1, 8'(i), 1'b0);
        step(1'b0, 8'h00, 1'b1);
        chk("pre_clear_valid", 32'(bus.rd_valid), 32'd1);
        @(negedge clk);
        #1;
        bus.wr_req = 1'b1;
        bus.rd_req = 1'b1;
        bus.clear  = 1'b1;
        #2;
        chk("clear_we", 32'(bus.mem_we), 32'd0);
        @(posedge clk);
        #2;
        chk("clear_count", 32'(bus.count), 32'd0);
        chk("clear_empty", 32'(bus.empty), 32'd1);
        chk("clear_wraddr", 32'(bus.mem_wraddr), 32'd0);
        chk("clear_rdaddr", 32'(bus.mem_rdaddr), 32'd0);
        chk("clear_valid", 32'(bus.rd_valid), 32'd0);

        for (int i = 0; i < 10; i++) step(1'b1, 8'(i), 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1);
        #1 rst_n = 1'b0;
        #1;
        chk("async_valid", 32'(bus.rd_valid), 32'd0);
        chk("async_count", 32'(bus.count), 32'd0);
        chk("async_empty", 32'(bus.empty), 32'd1);
        @(negedge clk);
        #1;
        bus.wr_req = 1'b0;
        bus.rd_req = 1'b0;
        rst_n      = 1'b1;

        for (int i = 0; i < 20000; i++) begin
            step(1'($urandom_range(0, 9) < 6), 8'($urandom), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 127) == 0));
        end
        step(1'b0, 8'h00, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
